pdm_stream: RTL and testbench

//  Parameterised stream demultiplexer. Routes one valid/ready input stream to one of N

---
 rtl/pdm_stream.sv | 83 ++++++++
 tb/tb_pdm_stream.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pdm_stream.sv
// Stream demultiplexer: one valid/ready input routed by s to one of N channels,
// each with a one-entry registered buffer. Out-of-range selects are dropped and counted.
module pdm_stream #(
    parameter int N  = 2,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [SW-1:0]  s,
    output logic [N-1:0]   out_valid,
    input  logic [N-1:0]   out_ready,
    output logic [N*W-1:0] out_data,
    output logic           err,
    output logic [15:0]    drop_cnt
);

    // Handshake: a word moves on any cycle where valid && ready are both high at the
    // rising edge; ready never depends on valid, and valid is never withdrawn by the DUT.

    localparam logic [0:0]  ST_EMPTY = 1'b0;
    localparam logic [0:0]  ST_FULL  = 1'b1;
    localparam logic [SW:0] NUM_CH   = (SW+1)'(N);

    logic [N-1:0] chan_state;
    logic         in_range;
    logic         accept;

    assign in_range  = ({1'b0, s} < NUM_CH);
    assign accept    = in_valid && in_ready;
    assign out_valid = chan_state;

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (!in_range) begin
                in_ready = 1'b1;
            end else begin
                in_ready = (chan_state[s] == ST_EMPTY) || out_ready[s];
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        logic         wr;
        logic [0:0]   state_r;
        logic [W-1:0] data_r;

        assign wr = accept && in_range && (s == SW'(k));

        // A write to a FULL buffer is only possible while it drains, so it simply replaces.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r <= ST_EMPTY;
                data_r  <= '0;
            end else if (wr) begin
                state_r <= ST_FULL;
                data_r  <= in_data;
            end else if (out_ready[k]) begin
                state_r <= ST_EMPTY;
            end
        end

        assign chan_state[k]      = state_r[0];
        assign out_data[k*W +: W] = data_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err <= accept && !in_range;
            if (accept && !in_range && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_stream.sv
// Bench for pdm_stream: directed steps on an N=4 and an N=3 instance sharing stimulus,
// then a random phase compared against per-channel queue models.
module tb_pdm_stream;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  s;
    logic [3:0]  out_ready;

    logic        ir4, err4, ir3, err3;
    logic [3:0]  ov4;
    logic [2:0]  ov3;
    logic [31:0] od4;
    logic [23:0] od3;
    logic [15:0] drop4, drop3;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    logic [7:0] exp_q [2][4][$];
    logic       exp_err [2];
    int         exp_drop [2];

    pdm_stream #(.N(4), .W(8)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
        .s(s), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .err(err4), .drop_cnt(drop4)
    );

    pdm_stream #(.N(3), .W(8)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .s(s), .out_valid(ov3), .out_ready(out_ready[2:0]), .out_data(od3),
        .err(err3), .drop_cnt(drop3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 4'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; s = 2'd0; in_data = 8'h00; out_ready = 4'b0;
        step();
        step();
        #1;
        check("rst_in_ready4", 32'(ir4), 32'd0);
        check("rst_in_ready3", 32'(ir3), 32'd0);
        check("rst_out_valid4", 32'(ov4), 32'd0);
        check("rst_out_data4", od4, 32'd0);
        check("rst_err3", 32'(err3), 32'd0);
        check("rst_drop3", 32'(drop3), 32'd0);

        // single word to channel 2, then a blocked second word
        rst = 1'b0; in_valid = 1'b1; s = 2'd2; in_data = 8'hA5;
        #1 check("t1_in_ready_empty", 32'(ir4), 32'd1);
        step();
        in_data = 8'h5A;
        #1;
        check("t1_out_valid", 32'(ov4), 32'h4);
        check("t1_out_data2", 32'(od4[23:16]), 32'hA5);
        check("t1_in_ready_full", 32'(ir4), 32'd0);

        // pass-through while draining
        out_ready = 4'b0100; in_data = 8'h3C;
        #1 check("t2_in_ready_drain", 32'(ir4), 32'd1);
        step();
        in_valid = 1'b0; out_ready = 4'b0;
        #1;
        check("t2_out_valid2", 32'(ov4[2]), 32'd1);
        check("t2_out_data2", 32'(od4[23:16]), 32'h3C);

        // fill all four channels, then drain all at once
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; s = 2'(i); in_data = 8'h10 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        #1;
        check("t3_all_full", 32'(ov4), 32'hF);
        check("t3_all_data", od4, 32'h13121110);
        out_ready = 4'hF;
        step();
        out_ready = 4'h0;
        #1;
        check("t3_all_drained", 32'(ov4), 32'h0);
        check("t3_data_held", od4, 32'h13121110);

        // out-of-range drop on N=3 with channel 1 occupied
        do_reset();
        in_valid = 1'b1; s = 2'd1; in_data = 8'h11;
        step();
        s = 2'd3; in_data = 8'h77;
        #1 check("t4_in_ready_oor", 32'(ir3), 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check("t4_err", 32'(err3), 32'd1);
        check("t4_drop", 32'(drop3), 32'd1);
        check("t4_out_valid_kept", 32'(ov3), 32'h2);
        check("t4_out_data_kept", 32'(od3[15:8]), 32'h11);
        step();
        #1;
        check("t4_err_one_cycle", 32'(err3), 32'd0);
        check("t4_drop_held", 32'(drop3), 32'd1);

        // back-to-back drops and saturation
        do_reset();
        in_valid = 1'b1; s = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            #1 check("t5_err_b2b", 32'(err3), 32'd1);
        end
        in_valid = 1'b0;
        check("t5_drop3", 32'(drop3), 32'd3);
        step();
        #1 check("t5_err_low", 32'(err3), 32'd0);
        in_valid = 1'b1;
        repeat (65532) step();
        in_valid = 1'b0;
        #1 check("t5_drop_reach_max", 32'(drop3), 32'hFFFF);
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        #1 check("t5_drop_saturated", 32'(drop3), 32'hFFFF);

        // reset mid-stream with buffered words
        in_valid = 1'b1; s = 2'd1; in_data = 8'hC3;
        step();
        in_valid = 1'b0;
        #1 check("t6_pre_full", 32'(ov4), 32'hA);
        rst = 1'b1; in_valid = 1'b1; s = 2'd0; in_data = 8'h99;
        #1;
        check("t6_in_ready4_rst", 32'(ir4), 32'd0);
        check("t6_in_ready3_rst", 32'(ir3), 32'd0);
        step();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("t6_out_valid4", 32'(ov4), 32'h0);
        check("t6_out_valid3", 32'(ov3), 32'h0);
        check("t6_drop3_cleared", 32'(drop3), 32'd0);
        in_valid = 1'b1; s = 2'd1; in_data = 8'h42;
        step();
        in_valid = 1'b0;
        #1;
        check("t6_route_after_rst", 32'(ov4), 32'h2);
        check("t6_data_after_rst", 32'(od4[15:8]), 32'h42);

        // random traffic against per-channel queue models
        do_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) exp_q[i][k].delete();
            exp_err[i] = 1'b0;
            exp_drop[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid  = 1'($urandom_range(0, 1));
            s         = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = 4'($urandom_range(0, 15));
            #1;
            for (int i = 0; i < 2; i++) begin
                int n;
                logic exp_ir;
                logic [3:0] exp_ov;
                logic [3:0] ov_v;
                logic [31:0] od_v;
                n      = (i == 0) ? 4 : 3;
                ov_v   = (i == 0) ? ov4 : {1'b0, ov3};
                od_v   = (i == 0) ? od4 : {8'h00, od3};
                exp_ir = (int'(s) >= n) || (exp_q[i][s].size() == 0) || out_ready[s];
                exp_ov = 4'b0;
                for (int k = 0; k < n; k++) exp_ov[k] = (exp_q[i][k].size() != 0);
                check("rnd_in_ready", 32'((i == 0) ? ir4 : ir3), 32'(exp_ir));
                check("rnd_out_valid", 32'(ov_v), 32'(exp_ov));
                check("rnd_err", 32'((i == 0) ? err4 : err3), 32'(exp_err[i]));
                check("rnd_drop", 32'((i == 0) ? drop4 : drop3), 32'(exp_drop[i]));
                for (int k = 0; k < n; k++) begin
                    if (exp_q[i][k].size() != 0)
                        check("rnd_out_data", 32'(od_v[k*8 +: 8]), 32'(exp_q[i][k][0]));
                end
                for (int k = 0; k < n; k++) begin
                    if (exp_q[i][k].size() != 0 && out_ready[k]) void'(exp_q[i][k].pop_front());
                end
                exp_err[i] = in_valid && exp_ir && (int'(s) >= n);
                if (exp_err[i] && exp_drop[i] < 65535) exp_drop[i]++;
                if (in_valid && exp_ir && int'(s) < n) exp_q[i][s].push_back(in_data);
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
